// File: rtl/roi_capture_pp.sv
// ROI capture with integer decimation, luma conversion and
// ping-pong source buffering towards the CNN engine.
module roi_capture_pp #(
    parameter int W_PIX   = 24,
    parameter int W_POS   = 12,
    parameter int W_ADDR  = 10,
    parameter int W_SCALE = 3,
    parameter int W_DROP  = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              enable,
    input  logic              vsync,
    input  logic              de,
    input  logic [W_PIX-1:0]  data,
    input  logic [W_POS-1:0]  x,
    input  logic [W_POS-1:0]  y,
    input  logic [W_POS-1:0]  w,
    input  logic [W_POS-1:0]  h,
    input  logic [W_SCALE-1:0] scale,
    output logic              wr_en,
    output logic [W_ADDR:0]   wr_addr,
    output logic [7:0]        wr_data,
    output logic              frame_ready,
    output logic              ready_bank,
    input  logic              release_req,
    input  logic              release_bank,
    output logic [1:0]        bank_full,
    output logic [W_DROP-1:0] drop_cnt
);

    typedef enum logic [1:0] {IDLE, ACTIVE, FINISH, DROP} state_t;

    state_t state, state_n;

    logic vs_d, de_d, vs_rise, de_fall;
    logic [W_POS-1:0] col, row, x_l, y_l, w_l, h_l, ccnt, rcnt;
    logic [W_SCALE-1:0] s_l, cph, rph;
    logic wbank;
    logic [W_ADDR-1:0] offset;
    logic start_ok, start_drop, eval, abort;
    logic col_in, row_in, smp, last, fr_set;
    logic [1:0] d_inc;
    logic [W_DROP:0] dsum;
    logic [9:0] lsum;
    logic [7:0] luma;

    assign vs_rise = vsync & ~vs_d;
    assign de_fall = ~de & de_d;

    assign lsum = {2'b0, data[W_PIX-1 -: 8]} + {1'b0, data[15:8], 1'b0}
                + {2'b0, data[7:0]};
    assign luma = 8'(lsum >> 2);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        start_ok   = enable && (w != '0) && (h != '0);
        start_drop = start_ok && bank_full[wbank];
        state_n    = state;
        unique case (state)
            IDLE, DROP: begin
                if (vs_rise)
                    state_n = !start_ok ? IDLE : start_drop ? DROP : ACTIVE;
            end
            ACTIVE: begin
                if (vs_rise)
                    state_n = !start_ok ? IDLE : start_drop ? DROP : ACTIVE;
                else if (smp && last)
                    state_n = FINISH;
            end
            FINISH: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // (col-x)%s and (row-y)%s are tracked by phase counters cph/rph
    always_comb begin
        col_in = (col >= x_l) && (ccnt < w_l);
        row_in = (row >= y_l) && (rcnt < h_l);
        smp    = (state == ACTIVE) && !vs_rise && de && col_in && row_in
               && (cph == '0) && (rph == '0);
        last   = (ccnt == w_l - 1'b1) && (rcnt == h_l - 1'b1);
        fr_set = (state == FINISH);
        eval   = vs_rise && (state != FINISH);
        abort  = vs_rise && (state == ACTIVE);
        d_inc  = {1'b0, abort} + {1'b0, eval & start_drop};
        dsum   = {1'b0, drop_cnt} + {{(W_DROP-1){1'b0}}, d_inc};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vs_d <= 1'b0;
            de_d <= 1'b0;
            col  <= '0;
            row  <= '0;
            cph  <= '0;
            ccnt <= '0;
            rph  <= '0;
            rcnt <= '0;
            x_l  <= '0;
            y_l  <= '0;
            w_l  <= '0;
            h_l  <= '0;
            s_l  <= W_SCALE'(1);
        end else begin
            vs_d <= vsync;
            de_d <= de;
            if (de)           col <= col + 1'b1;
            else if (de_d)    col <= '0;
            if (vs_rise)      row <= '0;
            else if (de_fall) row <= row + 1'b1;
            if (vs_rise || de_fall) begin
                cph  <= '0;
                ccnt <= '0;
            end else if (de && col_in) begin
                if (cph == '0) ccnt <= ccnt + 1'b1;
                cph <= (cph == s_l - 1'b1) ? '0 : cph + 1'b1;
            end
            if (vs_rise) begin
                rph  <= '0;
                rcnt <= '0;
            end else if (de_fall && row_in) begin
                if (rph == '0) rcnt <= rcnt + 1'b1;
                rph <= (rph == s_l - 1'b1) ? '0 : rph + 1'b1;
            end
            if (vs_rise) begin
                x_l <= x;
                y_l <= y;
                w_l <= w;
                h_l <= h;
                s_l <= (scale == '0) ? W_SCALE'(1) : scale;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            offset      <= '0;
            wbank       <= 1'b0;
            frame_ready <= 1'b0;
            ready_bank  <= 1'b0;
            bank_full   <= 2'b00;
            drop_cnt    <= '0;
        end else begin
            wr_en       <= smp;
            frame_ready <= fr_set;
            ready_bank  <= fr_set ? wbank : 1'b0;
            if (smp) begin
                wr_addr <= {wbank, offset};
                wr_data <= luma;
            end
            if (eval)     offset <= '0;
            else if (smp) offset <= offset + 1'b1;
            if (fr_set)   wbank  <= ~wbank;
            // completion of a bank beats a same-cycle release of it
            for (int i = 0; i < 2; i++) begin
                if (fr_set && (wbank == 1'(i)))
                    bank_full[i] <= 1'b1;
                else if (release_req && (release_bank == 1'(i)))
                    bank_full[i] <= 1'b0;
            end
            if (dsum[W_DROP]) drop_cnt <= '1;
            else              drop_cnt <= dsum[W_DROP-1:0];
        end
    end

endmodule

// File: doc/roi_capture_pp.md
Name: roi_capture_pp

Overview:
Parametrised successor to the single-window LeNet capture. Extracts a programmable rectangular region of interest from the incoming video stream with integer decimation. Converts each sampled pixel to 8-bit luma and writes it into a ping-pong (two-bank) source buffer. A bank-level handshake with the CNN engine prevents overwriting a frame still being consumed, and frames that cannot be stored are dropped and counted.

Parameters:
W_PIX, 24, input pixel width; R=[23:16], G=[15:8], B=[7:0] for default
W_POS, 12, width of x/y/w/h and internal column/row counters
W_ADDR, 10, per-bank address width; bank depth 2^W_ADDR
W_SCALE, 3, width of decimation factor
W_DROP, 16, width of dropped-frame counter

Ports:
clk  in  1  pixel clock
rstn  in  1  asynchronous active-low reset
enable  in  1  capture enable, sampled at frame start only
vsync  in  1  frame sync, active high; rising edge = frame start
de  in  1  active-pixel qualifier
data  in  W_PIX  pixel data
x, y  in  W_POS each  window origin in source pixels
w, h  in  W_POS each  output window size in sampled pixels
scale  in  W_SCALE  decimation factor; 0 treated as 1
wr_en  out  1  buffer write strobe
wr_addr  out  W_ADDR+1  {bank, offset}
wr_data  out  8  luma
frame_ready  out  1  one-cycle pulse: bank complete
ready_bank  out  1  bank just completed; valid with frame_ready
release  in  1  one-cycle pulse from consumer: bank free
release_bank  in  1  bank being released
bank_full  out  2  per-bank full flags
drop_cnt  out  W_DROP  saturating count of dropped/aborted frames

Behaviour:
- Reset values: wr_en=0, wr_addr=0, wr_data=0, frame_ready=0, ready_bank=0, bank_full=0, drop_cnt=0, write bank=0, state IDLE.
- Counters:
  - col increments per de cycle and clears on de falling edge.
  - row increments on each de falling edge and clears at vsync rising edge.
- At vsync rising edge, latch x, y, w, h, scale, enable; then decide:
  - enable=0, w=0 or h=0 -> IDLE, no writes, no drop.
  - bank_full[write bank]=1 -> DROP; drop_cnt+1, saturating.
  - otherwise -> ACTIVE; offset counter cleared.
- ACTIVE sampling: a pixel is sampled when de=1, x<=col<x+w*s, y<=row<y+h*s, (col-x)%s==0 and (row-y)%s==0, where s is the latched scale. Use modulo counters, not dividers.
- Luma = (R + 2G + B) >> 2, computed in 10 bits and truncated to 8 bits.
- Write timing: wr_en, wr_addr and wr_data are registered, asserting exactly 1 cycle after the sampled input pixel. wr_addr = {write bank, offset}; offset increments after each write and wraps modulo 2^W_ADDR if w*h exceeds depth.
- Frame completion: the cycle after the write of sample w*h-1, pulse frame_ready with ready_bank = write bank, set bank_full[write bank], toggle write bank, go to IDLE.
- Abort: a vsync rising edge while ACTIVE (window not completed, e.g. it extends past active video) aborts the frame. drop_cnt+1, bank not marked full, write bank unchanged, then the new frame is evaluated in the same cycle.
- DROP: no writes; returns to frame-start evaluation at the next vsync rising edge.
- release clears bank_full[release_bank] on the next edge.
  - Release of a bank that is not full: no effect.
  - Release of the bank set in the same cycle: set wins.
  - Release of the other bank in the same cycle as completion: both take effect.
- Reset asserted mid-frame: all state returns to reset values immediately. No frame_ready is issued for the partial frame.
- Parameter changes mid-frame have no effect until the next vsync rising edge.

Test Plan:
- Baseline capture: 64x40 raster, x=8, y=4, w=h=4, s=1, data ramp. Expect 16 writes, addr 0..15 bank 0, row-major. frame_ready with ready_bank=0 one cycle after the 16th write; bank_full=01.
- Decimation: s=3, w=h=4, x=y=0, pixel = {R=col, G=row, B=0}. Writes only at col,row in {0,3,6,9}. wr_data = (col+2*row)>>2, e.g. (9,9) -> 6.
- Ping-pong with drop: three frames, no release. Frames 1 and 2 complete on banks 0 and 1; frame 3 produces no writes; drop_cnt=1. Release bank 0, then frame 4 writes bank 0 (wr_addr[W_ADDR]=0).
- Abort: window y+h*s exceeds the raster line count. No frame_ready; drop_cnt increments at the next vsync; the next valid frame still writes bank 0 from offset 0.
- Simultaneous events: release_bank=1 coinciding with completion of bank 0 leaves bank_full=01. enable=0 or w=0 gives zero writes and drop_cnt unchanged.
- Reset mid-frame: rstn low after 5 writes. All outputs return to 0 asynchronously; the next frame starts at bank 0, offset 0.
